// File: rtl/polar_encoder.sv
// Iterative polar encoder: one butterfly stage per cycle over an N-bit work register,
// producing x = u' * F^(kron n) in natural order with a valid/ready handshake on both sides.
module polar_encoder #(
  parameter int unsigned N     = 16,
  parameter int unsigned LOG2N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_u,
  input  logic [N-1:0] in_frozen,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_x,
  output logic         busy
);

  localparam int unsigned SW = $clog2(LOG2N) + 1;
  localparam logic [SW-1:0] LastStage = SW'(LOG2N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ENC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [N-1:0]  work_q, work_d;
  logic [N-1:0]  stage_x;

  // Butterfly for the current stage: partner index is i with bit s set.
  always_comb begin
    stage_x = work_q;
    for (int s = 0; s < int'(LOG2N); s++) begin
      if (stage_q == SW'(s)) begin
        for (int i = 0; i < int'(N); i++) begin
          if (((i >> s) & 1) == 0) begin
            stage_x[i] = work_q[i] ^ work_q[i | (1 << s)];
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    work_d  = work_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_u & ~in_frozen;
          stage_d = '0;
          state_d = ENC;
        end
      end
      ENC: begin
        work_d  = stage_x;
        stage_d = stage_q + 1'b1;
        if (stage_q == LastStage) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stage_q <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      work_q  <= work_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_x     = work_q;

endmodule

// File: tb/tb_polar_encoder.sv
// Directed and random bench for polar_encoder (N=16): a negedge monitor scores every
// accepted message against an independent subset-XOR reference model.
module tb_polar_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_u;
  logic [15:0] in_frozen;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_x;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int popped = 0;
  int aborted = 0;
  logic [15:0] exp_q[$];

  polar_encoder #(
    .N    (16),
    .LOG2N(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_u     (in_u),
    .in_frozen(in_frozen),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_x    (out_x),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // x[i] is the XOR of u'[k] over every k whose set bits include those of i.
  function automatic logic [15:0] ref_enc(input logic [15:0] u, input logic [15:0] f);
    logic [15:0] up;
    logic [15:0] x;
    up = u & ~f;
    x  = '0;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 16; k++) begin
        if ((k & i) == i) x[i] = x[i] ^ up[k];
      end
    end
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_and_valid", {31'd0, in_ready & out_valid}, 32'd0);
      chk("busy_vs_ready", {31'd0, busy}, {31'd0, ~in_ready});
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_enc(in_u, in_frozen));
        accepted++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("out_with_empty_queue", {31'd0, out_valid}, 32'd0);
        end else begin
          popped++;
          chk("out_x_scoreboard", {16'd0, out_x}, {16'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Called at posedge+2; returns at the accepting edge +2.
  task automatic drive_msg(input logic [15:0] u, input logic [15:0] f);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("wait_in_ready", {31'd0, in_ready}, 32'd1);
    in_u      = u;
    in_frozen = f;
    in_valid  = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  // Counts edges after the accepting edge until out_valid; returns at posedge+2.
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cyc;
    int target;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_u      = '0;
    in_frozen = '0;
    out_ready = 1'b1;
    #3;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_x", {16'd0, out_x}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #2;

    drive_msg(16'h8000, 16'h0000);
    wait_done(lat);
    chk("latency_8000", lat, 4);
    chk("out_x_8000", {16'd0, out_x}, 32'h0000_FFFF);
    @(posedge clk);
    #2;

    drive_msg(16'h0003, 16'h0000);
    wait_done(lat);
    chk("latency_0003", lat, 4);
    chk("out_x_0003", {16'd0, out_x}, 32'h0000_0002);
    @(posedge clk);
    #2;

    drive_msg(16'hFFFF, 16'h7FFF);
    wait_done(lat);
    chk("out_x_frozen", {16'd0, out_x}, 32'h0000_FFFF);
    @(posedge clk);
    #2;

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    drive_msg(16'h0001, 16'h0000);
    wait_done(lat);
    chk("latency_0001", lat, 4);
    for (int c = 0; c < 10; c++) begin
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_out_x", {16'd0, out_x}, 32'h0000_0001);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #2;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    #1;

    // Reset in the second ENC cycle aborts the codeword.
    drive_msg(16'h1234, 16'h0000);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_out_x", {16'd0, out_x}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    aborted += exp_q.size();
    exp_q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
      #1;
    end
    drive_msg(16'hA5C3, 16'h0F00);
    wait_done(lat);
    chk("post_abort_latency", lat, 4);
    chk("post_abort_out_x", {16'd0, out_x}, {16'd0, ref_enc(16'hA5C3, 16'h0F00)});
    @(posedge clk);
    #2;

    target = accepted + 1000;
    cyc = 0;
    while (accepted < target && cyc < 40000) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_u      = 16'($urandom);
      in_frozen = 16'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #2;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while ((exp_q.size() != 0 || busy) && cyc < 40) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    chk("random_accepted", {31'd0, accepted >= target}, 32'd1);
    chk("queue_drained", exp_q.size(), 0);
    chk("no_drop_or_dup", popped, accepted - aborted);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/polar_encoder.md
POLAR_ENCODER -- requirements
Module: polar_encoder

Interface
REQ-001 SHALL have parameter N, default 16, meaning the code length; legal values are powers of two from 2 to 1024.
REQ-002 SHALL have parameter LOG2N, default 4, meaning log2(N); the values of N and LOG2N are consistent by construction.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  in_u/in_frozen carry a valid message.
REQ-006 in_ready  output  1  block can accept a message.
REQ-007 in_u  input  N  source vector u; bit i is u[i].
REQ-008 in_frozen  input  N  frozen mask; bit i = 1 forces u[i] to 0.
REQ-009 out_valid  output  1  out_x holds a finished codeword.
REQ-010 out_ready  input  1  downstream accepts out_x.
REQ-011 out_x  output  N  codeword x; bit i is x[i].
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, ENC and DONE.
REQ-014 SHALL assert in_ready only in IDLE; in_ready is driven combinationally from the state.
REQ-015 In IDLE, a handshake (in_valid & in_ready) SHALL:
- load the work register with in_u & ~in_frozen;
- clear the stage counter to 0;
- go to ENC.
REQ-016 In IDLE with in_valid low, the FSM and the work register SHALL hold.
REQ-017 In ENC, each cycle SHALL apply butterfly stage s = stage counter:
- for every i with bit s of i equal to 0, x[i] <= x[i] ^ x[i + 2^s];
- x[i + 2^s] is unchanged;
- all N/2 XORs are evaluated in parallel from the pre-stage register value.
REQ-018 In ENC, the stage counter SHALL increment each cycle; the cycle that applies stage LOG2N-1 SHALL go to DONE.
REQ-019 The result SHALL be x[i] = XOR of u'[k] over all k whose bit set contains that of i, where u' = in_u & ~in_frozen. This equals u'·F^(⊗n), natural order, no bit-reversal.
REQ-020 out_valid SHALL be high exactly in DONE, and out_x SHALL equal the work register.
REQ-021 Latency: out_valid SHALL rise LOG2N clock edges after the accepting edge.
REQ-022 In DONE with out_ready low, out_valid and out_x SHALL hold stable for any number of cycles.
REQ-023 In DONE with out_ready high, the FSM SHALL go to IDLE on that edge.
REQ-024 Maximum throughput SHALL be one codeword per LOG2N+2 cycles; in_ready SHALL never be asserted while out_valid is high.
REQ-025 in_valid, in_u and in_frozen SHALL be ignored outside IDLE.
REQ-026 out_ready SHALL be ignored outside DONE.
REQ-027 The stage counter SHALL be ceil(log2(LOG2N))+1 bits wide, and SHALL never exceed LOG2N-1 while in ENC.
REQ-028 For N=2 (LOG2N=1), ENC SHALL last exactly one cycle.

Reset
REQ-029 rst_n low SHALL immediately force all of the following, regardless of clock:
- state=IDLE, stage counter=0, work register=0;
- out_valid=0, out_x=0, busy=0;
- in_ready=1 once rst_n is high.
REQ-030 Reset asserted during ENC or DONE SHALL abort the codeword; no out_valid pulse SHALL follow for it.

Verification (N=16)
REQ-031 in_u=16'h8000, in_frozen=0, out_ready=1 -> out_valid 4 edges after acceptance, out_x=16'hFFFF.
REQ-032 in_u=16'h0003, in_frozen=0 -> out_x=16'h0002.
REQ-033 in_u=16'hFFFF, in_frozen=16'h7FFF -> out_x=16'hFFFF.
REQ-034 in_u=16'h0001, out_ready held low 10 cycles -> out_valid=1 and out_x=16'h0001 stable throughout; in_ready=0 throughout; IDLE on the edge after out_ready rises.
REQ-035 Accept a message, pulse rst_n low on the 2nd ENC cycle -> out_valid stays 0 and out_x=0; next message encodes correctly.
REQ-036 1000 random in_u/in_frozen pairs with random out_ready -> every out_x matches a reference u'·F^(⊗4) model, no message dropped or duplicated.
